// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path.
// States, opcodes, ALU/mux select codes and the strobe bundle.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       done;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) ||
           (op == OP_SW)    || (op == OP_BEQ) ||
           (op == OP_ADDI)  || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Combinational state -> strobe mapping for the main controller.
// Ports: state, ready (memory handshake), zero (ALU flag) -> ctrl bundle.
import mips_ctrl_pkg::*;

module mc_out_decode (
  input  state_t state,
  input  logic   ready,
  input  logic   zero,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_4;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCS_ALU;
        // IR and PC only update once the fetch really completes
        ctrl.ir_write  = ready;
        ctrl.pc_write  = ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMMSH;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.done       = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        ctrl.done      = ready;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        ctrl.done      = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_source = PCS_ALUOUT;
        ctrl.pc_write  = zero;
        ctrl.done      = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_source = PCS_JUMP;
        ctrl.pc_write  = 1'b1;
        ctrl.done      = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.done      = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multicycle MIPS main control FSM: state register, opcode latch, next state.
// Ports: clk_i, rst_i (async low), Opcode_i, Zero_i, mem_ready_i -> strobes.
import mips_ctrl_pkg::*;

module mc_main_ctrl (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] Opcode_i,
  input  logic       Zero_i,
  input  logic       mem_ready_i,
  output logic       IorD_o,
  output logic       MemRead_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic       RegDst_o,
  output logic       MemtoReg_o,
  output logic       RegWrite_o,
  output logic       ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [1:0] ALU_OP_o,
  output logic [1:0] PCSource_o,
  output logic       PCWrite_o,
  output logic       illegal_o,
  output logic       instr_done_o,
  output logic [3:0] state_o
);

  state_t     state_q;
  state_t     state_d;
  logic [5:0] op_q;
  logic       illegal;
  ctrl_t      ctrl;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE)
        op_q <= Opcode_i;
    end
  end

  assign illegal = (state_q == S_DECODE) && !op_legal(Opcode_i);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready_i) state_d = S_DECODE;
      S_DECODE: begin
        unique case (Opcode_i)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      // later states use the latched opcode, not the live input
      S_MEMADR: state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready_i) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready_i) state_d = S_FETCH;
      S_EXEC:   state_d = S_RWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_RWB, S_BRANCH,
      S_JUMP, S_ADDIWB: state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  mc_out_decode u_dec (
    .state (state_q),
    .ready (mem_ready_i),
    .zero  (Zero_i),
    .ctrl  (ctrl)
  );

  assign IorD_o       = ctrl.iord;
  assign MemRead_o    = ctrl.mem_read;
  assign MemWrite_o   = ctrl.mem_write;
  assign IRWrite_o    = ctrl.ir_write;
  assign RegDst_o     = ctrl.reg_dst;
  assign MemtoReg_o   = ctrl.mem_to_reg;
  assign RegWrite_o   = ctrl.reg_write;
  assign ALUSrcA_o    = ctrl.alu_src_a;
  assign ALUSrcB_o    = ctrl.alu_src_b;
  assign ALU_OP_o     = ctrl.alu_op;
  assign PCSource_o   = ctrl.pc_source;
  assign PCWrite_o    = ctrl.pc_write;
  assign illegal_o    = illegal;
  assign instr_done_o = ctrl.done | illegal;
  assign state_o      = state_q;

endmodule
